// File: rtl/io_latch_ctrl.sv
// io_latch_ctrl: write sequencer and arbiter for a bank of 74ALS74-style output latches.
// Two requesters (A, B) share one latch write port. A granted write runs
// SETUP -> STROBE -> HOLDS -> DONE so latch_d is stable around the clock-enable
// strobe. Bank-wide presets drive latch_sn low for PRE_CYC cycles. Every output
// comes straight from a flop.
//
// Ports:
//   clk, rst               system clock; synchronous active-high reset
//   a_req/a_sel/a_data     requester A: level request, target latch, data
//   b_req/b_sel/b_data     requester B: same as A
//   a_gnt/b_gnt            one-cycle grant pulse (in the SETUP cycle)
//   a_done/b_done          one-cycle completion pulse (in the DONE cycle)
//   preset_req             one-cycle request to preset every latch
//   latch_d                data to the latch bank
//   latch_ce               one-hot clock enable, high only in STROBE
//   latch_sn               active-low preset, all bits driven together
//   busy                   high in every state except IDLE
//   bad_sel                sticky: a granted sel was out of range
module io_latch_ctrl #(
    parameter int unsigned NLATCH  = 4,
    parameter int unsigned DW      = 8,
    parameter int unsigned HOLD    = 2,
    parameter int unsigned PRE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic [2:0]        a_sel,
    input  logic [DW-1:0]     a_data,
    input  logic              b_req,
    input  logic [2:0]        b_sel,
    input  logic [DW-1:0]     b_data,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_done,
    output logic              b_done,
    input  logic              preset_req,
    output logic [DW-1:0]     latch_d,
    output logic [NLATCH-1:0] latch_ce,
    output logic [NLATCH-1:0] latch_sn,
    output logic              busy,
    output logic              bad_sel
);

    typedef enum logic [2:0] {
        StPreset,
        StIdle,
        StSetup,
        StStrobe,
        StHolds,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ptr_q, ptr_d;     // 1: B won last, so A wins the next tie
    logic        pend_q, pend_d;   // preset waiting for the next IDLE
    logic        owner_q, owner_d; // 0: A owns the transaction, 1: B
    logic [2:0]  sel_q, sel_d;
    logic [DW-1:0] data_q, data_d;
    logic        bad_q, bad_d;

    // Output flops; their next values are decoded from the next state.
    logic              a_gnt_q, a_gnt_d;
    logic              b_gnt_q, b_gnt_d;
    logic              a_done_q, a_done_d;
    logic              b_done_q, b_done_d;
    logic [DW-1:0]     latch_d_q, latch_d_d;
    logic [NLATCH-1:0] latch_ce_q, latch_ce_d;
    logic [NLATCH-1:0] latch_sn_q, latch_sn_d;
    logic              busy_q, busy_d;

    logic a_win, b_win;

    function automatic logic sel_ok(input logic [2:0] s);
        return 32'(s) < NLATCH;
    endfunction

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        pend_d  = pend_q | preset_req;
        owner_d = owner_q;
        sel_d   = sel_q;
        data_d  = data_q;
        bad_d   = bad_q;
        a_win   = a_req && (!b_req || ptr_q);
        b_win   = b_req && !a_win;

        unique case (state_q)
            StPreset: begin
                if (cnt_q == 4'(PRE_CYC - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StIdle: begin
                if (pend_q || preset_req) begin
                    // Preset beats both requesters; flag clears on entry.
                    state_d = StPreset;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end else if (a_win || b_win) begin
                    state_d = StSetup;
                    owner_d = b_win;
                    ptr_d   = b_win;
                    sel_d   = b_win ? b_sel : a_sel;
                    data_d  = b_win ? b_data : a_data;
                    if (!sel_ok(sel_d)) begin
                        bad_d = 1'b1;
                    end
                end
            end
            StSetup: state_d = StStrobe;
            StStrobe: begin
                state_d = StHolds;
                cnt_d   = '0;
            end
            StHolds: begin
                if (cnt_q == 4'(HOLD - 1)) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StPreset;
        endcase
    end

    // Registered-output decode from the next state
    always_comb begin
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_done_d   = 1'b0;
        b_done_d   = 1'b0;
        latch_d_d  = '0;
        latch_ce_d = '0;
        latch_sn_d = '1;
        busy_d     = (state_d != StIdle);

        if (state_q == StIdle && state_d == StSetup) begin
            a_gnt_d = !owner_d;
            b_gnt_d = owner_d;
        end
        if (state_d == StDone) begin
            a_done_d = !owner_d;
            b_done_d = owner_d;
        end
        if (state_d inside {StSetup, StStrobe, StHolds, StDone}) begin
            latch_d_d = data_d;
        end
        if (state_d == StStrobe && sel_ok(sel_d)) begin
            latch_ce_d = NLATCH'(1) << sel_d;
        end
        if (state_d == StPreset) begin
            latch_sn_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StPreset;
            cnt_q      <= '0;
            ptr_q      <= 1'b1;
            pend_q     <= 1'b0;
            owner_q    <= 1'b0;
            sel_q      <= '0;
            data_q     <= '0;
            bad_q      <= 1'b0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_done_q   <= 1'b0;
            b_done_q   <= 1'b0;
            latch_d_q  <= '0;
            latch_ce_q <= '0;
            latch_sn_q <= '0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            pend_q     <= pend_d;
            owner_q    <= owner_d;
            sel_q      <= sel_d;
            data_q     <= data_d;
            bad_q      <= bad_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            a_done_q   <= a_done_d;
            b_done_q   <= b_done_d;
            latch_d_q  <= latch_d_d;
            latch_ce_q <= latch_ce_d;
            latch_sn_q <= latch_sn_d;
            busy_q     <= busy_d;
        end
    end

    assign a_gnt    = a_gnt_q;
    assign b_gnt    = b_gnt_q;
    assign a_done   = a_done_q;
    assign b_done   = b_done_q;
    assign latch_d  = latch_d_q;
    assign latch_ce = latch_ce_q;
    assign latch_sn = latch_sn_q;
    assign busy     = busy_q;
    assign bad_sel  = bad_q;

endmodule

// File: tb/tb_io_latch_ctrl.sv
// Directed bench for io_latch_ctrl with default parameters
// (NLATCH=4, DW=8, HOLD=2, PRE_CYC=2). Inputs change #1 after a rising edge;
// outputs are checked at the same point, i.e. they show the cycle just begun.
module tb_io_latch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, b_req, preset_req;
    logic [2:0] a_sel, b_sel;
    logic [7:0] a_data, b_data;
    logic       a_gnt, b_gnt, a_done, b_done, busy, bad_sel;
    logic [7:0] latch_d;
    logic [3:0] latch_ce, latch_sn;

    int nvec = 0;
    int nerr = 0;

    io_latch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .a_req      (a_req),
        .a_sel      (a_sel),
        .a_data     (a_data),
        .b_req      (b_req),
        .b_sel      (b_sel),
        .b_data     (b_data),
        .a_gnt      (a_gnt),
        .b_gnt      (b_gnt),
        .a_done     (a_done),
        .b_done     (b_done),
        .preset_req (preset_req),
        .latch_d    (latch_d),
        .latch_ce   (latch_ce),
        .latch_sn   (latch_sn),
        .busy       (busy),
        .bad_sel    (bad_sel)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic exp_a, exp_b;

    initial begin
        rst = 1'b1; a_req = 0; b_req = 0; preset_req = 0;
        a_sel = 0; b_sel = 0; a_data = 0; b_data = 0;

        // Reset values
        tick();
        chk("rst_sn", 32'(latch_sn), 32'h0);
        chk("rst_ce", 32'(latch_ce), 32'h0);
        chk("rst_d", 32'(latch_d), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
        chk("rst_gnt", 32'({a_gnt, b_gnt, a_done, b_done, bad_sel}), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        // Cycle R: first PRESET cycle after reset release
        chk("pre0_sn", 32'(latch_sn), 32'h0);
        tick();
        chk("pre1_sn", 32'(latch_sn), 32'h0);
        chk("pre1_busy", 32'(busy), 32'h1);
        tick();
        chk("idle_sn", 32'(latch_sn), 32'hF);
        chk("idle_busy", 32'(busy), 32'h0);

        // Lone write from A: N is this IDLE cycle
        a_req = 1; a_sel = 3'd1; a_data = 8'hA5;
        tick(); // N+1
        chk("lone_agnt", 32'(a_gnt), 32'h1);
        chk("lone_bgnt", 32'(b_gnt), 32'h0);
        chk("lone_setup_d", 32'(latch_d), 32'hA5);
        chk("lone_setup_ce", 32'(latch_ce), 32'h0);
        a_req = 0;
        tick(); // N+2
        chk("lone_ce", 32'(latch_ce), 32'h2);
        chk("lone_strobe_d", 32'(latch_d), 32'hA5);
        chk("lone_gnt_off", 32'(a_gnt), 32'h0);
        tick(); // N+3
        chk("lone_hold_ce", 32'(latch_ce), 32'h0);
        chk("lone_hold_d", 32'(latch_d), 32'hA5);
        tick(); // N+4
        chk("lone_done_early", 32'(a_done), 32'h0);
        tick(); // N+5
        chk("lone_done", 32'(a_done), 32'h1);
        chk("lone_done_d", 32'(latch_d), 32'hA5);
        tick(); // N+6
        chk("lone_idle_busy", 32'(busy), 32'h0);
        chk("lone_idle_d", 32'(latch_d), 32'h0);
        chk("lone_done_off", 32'(a_done), 32'h0);

        // Contention: A won last, so B wins first, then alternate every 6 cycles
        a_req = 1; a_sel = 3'd0; a_data = 8'h11;
        b_req = 1; b_sel = 3'd2; b_data = 8'h22;
        for (int off = 1; off <= 23; off++) begin
            tick();
            exp_b = ((off / 6) % 2) == 0;
            exp_a = !exp_b;
            chk($sformatf("rr_agnt_%0d", off), 32'(a_gnt), 32'(exp_a && (off % 6 == 1)));
            chk($sformatf("rr_bgnt_%0d", off), 32'(b_gnt), 32'(exp_b && (off % 6 == 1)));
            chk($sformatf("rr_ce_%0d", off), 32'(latch_ce),
                (off % 6 == 2) ? (exp_b ? 32'h4 : 32'h1) : 32'h0);
            chk($sformatf("rr_adone_%0d", off), 32'(a_done), 32'(exp_a && (off % 6 == 5)));
            chk($sformatf("rr_bdone_%0d", off), 32'(b_done), 32'(exp_b && (off % 6 == 5)));
        end
        a_req = 0; b_req = 0;
        tick(); // IDLE, A won last
        chk("rr_idle_busy", 32'(busy), 32'h0);

        // Preset priority: P is this IDLE cycle
        b_req = 1; b_sel = 3'd3; b_data = 8'h3C;
        tick(); // P+1
        chk("pp_bgnt", 32'(b_gnt), 32'h1);
        b_req = 0;
        a_req = 1; a_sel = 3'd2; a_data = 8'h5A;
        tick(); // P+2 STROBE
        chk("pp_ce", 32'(latch_ce), 32'h8);
        chk("pp_d", 32'(latch_d), 32'h3C);
        preset_req = 1;
        tick(); // P+3
        preset_req = 0;
        tick(); // P+4
        tick(); // P+5
        chk("pp_bdone", 32'(b_done), 32'h1);
        chk("pp_agnt_wait", 32'(a_gnt), 32'h0);
        tick(); // P+6 IDLE, preset pending
        chk("pp_idle_sn", 32'(latch_sn), 32'hF);
        tick(); // P+7
        chk("pp_pre0_sn", 32'(latch_sn), 32'h0);
        chk("pp_pre0_busy", 32'(busy), 32'h1);
        chk("pp_pre0_agnt", 32'(a_gnt), 32'h0);
        tick(); // P+8
        chk("pp_pre1_sn", 32'(latch_sn), 32'h0);
        tick(); // P+9 IDLE
        chk("pp_idle2_sn", 32'(latch_sn), 32'hF);
        chk("pp_idle2_agnt", 32'(a_gnt), 32'h0);
        tick(); // P+10
        chk("pp_agnt", 32'(a_gnt), 32'h1);
        a_req = 0;
        tick(); // P+11
        chk("pp_ace", 32'(latch_ce), 32'h4);
        chk("pp_ad", 32'(latch_d), 32'h5A);
        tick(); tick(); tick(); // P+14
        chk("pp_adone", 32'(a_done), 32'h1);
        tick(); // P+15 IDLE

        // Bad select
        chk("bad_before", 32'(bad_sel), 32'h0);
        b_req = 1; b_sel = 3'd5; b_data = 8'h77;
        tick(); // Q+1
        chk("bad_bgnt", 32'(b_gnt), 32'h1);
        chk("bad_set", 32'(bad_sel), 32'h1);
        b_req = 0;
        tick(); // Q+2
        chk("bad_ce", 32'(latch_ce), 32'h0);
        chk("bad_d", 32'(latch_d), 32'h77);
        tick(); tick(); tick(); // Q+5
        chk("bad_bdone", 32'(b_done), 32'h1);
        tick(); // Q+6 IDLE
        chk("bad_idle_busy", 32'(busy), 32'h0);
        chk("bad_sticky", 32'(bad_sel), 32'h1);

        // Reset during HOLDS
        a_req = 1; a_sel = 3'd0; a_data = 8'h99;
        tick(); // S+1
        chk("mr_agnt", 32'(a_gnt), 32'h1);
        tick(); // S+2
        chk("mr_ce", 32'(latch_ce), 32'h1);
        tick(); // S+3 HOLDS
        rst = 1;
        tick(); // S+4 reset applied
        chk("mr_done", 32'(a_done), 32'h0);
        chk("mr_ce0", 32'(latch_ce), 32'h0);
        chk("mr_sn", 32'(latch_sn), 32'h0);
        chk("mr_busy", 32'(busy), 32'h1);
        chk("mr_bad_clr", 32'(bad_sel), 32'h0);
        chk("mr_d", 32'(latch_d), 32'h0);
        rst = 0;
        tick(); // S+5
        chk("mr_pre_sn", 32'(latch_sn), 32'h0);
        chk("mr_pre_done", 32'(a_done), 32'h0);
        chk("mr_pre_gnt", 32'(a_gnt), 32'h0);
        tick(); // S+6 IDLE
        chk("mr_idle_sn", 32'(latch_sn), 32'hF);
        chk("mr_idle_gnt", 32'(a_gnt), 32'h0);
        tick(); // S+7
        chk("mr_regnt", 32'(a_gnt), 32'h1);
        a_req = 0;
        tick(); tick(); tick(); tick(); // S+11
        chk("mr_redone", 32'(a_done), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
